// File: rtl/csa_pkg.sv
// Shared types and elaboration-time helpers for the pipelined carry-select adder.
// Optional subtract mode is enabled by defining CSA_PIPE_SUB_EN.
package csa_pkg;

  // Control part of a pipeline stage record; the width-dependent fields
  // (resolved sum, pending operands) are added by the top, which knows WIDTH.
  typedef struct packed {
    logic valid;
    logic carry;
    logic cmsb;
    logic op_sub;
  } csa_ctl_t;

  function automatic int csa_nseg(input int width, input int seg);
    return width / seg;
  endfunction

  function automatic int csa_lat(input int width, input int seg, input int sps);
    return (csa_nseg(width, seg) + sps - 1) / sps;
  endfunction

  function automatic bit csa_cfg_ok(input int width, input int seg, input int sps);
    return (seg > 0) && (width >= seg) && (width % seg == 0) &&
           (sps >= 1) && (sps <= width / seg);
  endfunction

endpackage

// File: rtl/csa_seg.sv
// One carry-select segment: two ripple sums (carry-in 0 and 1) and a select mux.
// Also reports the carry into the segment MSB for signed-overflow detection.
module csa_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a_seg,
  input  logic [SEG-1:0] b_seg,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  logic [SEG:0]   c0;
  logic [SEG:0]   c1;
  logic [SEG-1:0] s0;
  logic [SEG-1:0] s1;

  always_comb begin
    c0    = '0;
    c1    = '0;
    s0    = '0;
    s1    = '0;
    c1[0] = 1'b1;
    for (int i = 0; i < SEG; i++) begin
      s0[i]   = a_seg[i] ^ b_seg[i] ^ c0[i];
      c0[i+1] = (a_seg[i] & b_seg[i]) | (c0[i] & (a_seg[i] ^ b_seg[i]));
      s1[i]   = a_seg[i] ^ b_seg[i] ^ c1[i];
      c1[i+1] = (a_seg[i] & b_seg[i]) | (c1[i] & (a_seg[i] ^ b_seg[i]));
    end
  end

  assign sum  = cin ? s1 : s0;
  assign cout = cin ? c1[SEG] : c0[SEG];
  assign cmsb = cin ? c1[SEG-1] : c0[SEG-1];

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder with valid/ready flow control and carry/overflow flags.
// Define CSA_PIPE_SUB_EN to add the op_sub port (a + ~b + 1 subtract mode).
module csa_pipe_adder
  import csa_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int SEG          = 4,
  parameter int SEGS_PER_STG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef CSA_PIPE_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov
);

  localparam int NSEG = csa_nseg(WIDTH, SEG);
  localparam int SPS  = SEGS_PER_STG;
  localparam int LAT  = csa_lat(WIDTH, SEG, SPS);

  if (!csa_cfg_ok(WIDTH, SEG, SPS)) begin : g_cfg_err
    $error("csa_pipe_adder: WIDTH must be a multiple of SEG and SEGS_PER_STG in 1..WIDTH/SEG");
  end

  // Stage record: resolved sum bits so far, operands still travelling with the
  // transaction, and the carry out of the last resolved segment.
  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    csa_ctl_t         ctl;
  } stg_t;

  // Handshake: a transfer happens on any edge where valid && ready. The whole
  // pipe advances together when en=1 and freezes (outputs included) when en=0.
  logic en;
  logic sub_w;
  stg_t head;

`ifdef CSA_PIPE_SUB_EN
  assign sub_w = op_sub;
`else
  assign sub_w = 1'b0;
`endif

  always_comb begin
    head            = '0;
    head.a          = a;
    head.b          = sub_w ? ~b : b;
    head.ctl.valid  = in_valid && en;
    head.ctl.carry  = sub_w ? 1'b1 : ci;
    head.ctl.op_sub = sub_w;
  end

  for (genvar k = 0; k < LAT; k++) begin : g_stg
    localparam int FIRST = k * SPS;
    localparam int NS    = ((NSEG - FIRST) < SPS) ? (NSEG - FIRST) : SPS;
    localparam bit LAST  = (FIRST + NS) == NSEG;

    stg_t              cur;
    stg_t              nxt;
    stg_t              q;
    logic [NS*SEG-1:0] sum_w;
    logic [NS-1:0]     cmsb_w;
    logic              unused_cmsb;

    if (k == 0) begin : g_head
      assign cur = head;
    end else begin : g_link
      assign cur = g_stg[k-1].q;
    end

    for (genvar j = 0; j < NS; j++) begin : g_seg
      logic           cin_l;
      logic           cout_l;
      logic [SEG-1:0] sum_l;

      if (j == 0) begin : g_cin_reg
        assign cin_l = cur.ctl.carry;
      end else begin : g_cin_chain
        assign cin_l = g_seg[j-1].cout_l;
      end

      csa_seg #(.SEG(SEG)) u_seg (
        .a_seg (cur.a[(FIRST+j)*SEG +: SEG]),
        .b_seg (cur.b[(FIRST+j)*SEG +: SEG]),
        .cin   (cin_l),
        .sum   (sum_l),
        .cout  (cout_l),
        .cmsb  (cmsb_w[j])
      );

      assign sum_w[j*SEG +: SEG] = sum_l;
    end

    // Only the adder's top segment contributes the MSB carry used for ov.
    assign unused_cmsb = ^cmsb_w;

    always_comb begin
      nxt                        = cur;
      nxt.sum[FIRST*SEG +: NS*SEG] = sum_w;
      nxt.ctl.carry              = g_seg[NS-1].cout_l;
      if (LAST) begin
        nxt.ctl.cmsb = cmsb_w[NS-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        q <= '0;
      end else if (en) begin
        q <= nxt;
      end
    end
  end

  assign en        = !g_stg[LAT-1].q.ctl.valid || out_ready;
  assign in_ready  = en;
  assign out_valid = g_stg[LAT-1].q.ctl.valid;
  assign s         = g_stg[LAT-1].q.sum;
  assign co        = g_stg[LAT-1].q.ctl.carry;
  assign ov        = g_stg[LAT-1].q.ctl.cmsb ^ g_stg[LAT-1].q.ctl.carry;

  // Operands are fully consumed by the last stage; op_sub only rides along.
  logic unused_tail;
  assign unused_tail = ^{g_stg[LAT-1].q.a, g_stg[LAT-1].q.b, g_stg[LAT-1].q.ctl.op_sub};

endmodule
